pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall/flush controller for the 5-stage core. It consumes the decode-stage load-use hazard flag, the execute-stage branch redirect and the multdiv handshake. From these it drives the PC and latch enables, bubble insertion and the one-shot multdiv start. The multdiv wait is a small state machine with a timeout watchdog, so a hung multdiv unit cannot freeze the pipeline.

## Interface
Parameters:
- MD_TIMEOUT, 48: maximum cycles spent in MD_BUSY before forced release; legal range 2..(2^CNT_W − 1).
- CNT_W, 6: width of the multdiv wait counter.

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_use_hazard  input  1  from the load-use detector; the F/D instruction needs the D/X load result.
- branch_taken  input  1  the X-stage instruction redirects the PC this cycle.
- md_insn  input  1  the D/X latch holds a valid mult or div.
- md_ready  input  1  multdiv result valid; single-cycle pulse.
- pc_en  output  1  PC register write enable.
- fd_en  output  1  F/D latch write enable.
- dx_en  output  1  D/X latch write enable.
- dx_bubble  output  1  load a nop into D/X instead of the decoded instruction.
- xm_bubble  output  1  load a nop into X/M.
- fd_flush, dx_flush  output  1  clear the F/D and D/X latches to nop.
- md_go  output  1  start pulse to the multdiv unit.
- md_timeout  output  1  one-cycle pulse when the watchdog fires.
- stall_count  output  32  stall-cycle counter; see Configuration.

## Operation
- States: RUN, MD_BUSY. Reset state is RUN, wait counter is 0.
- While reset_n is low, all outputs are 0 (every enable deasserted), and the FSM and counters are held at reset values.
- RUN, priority order, highest first:
  1. branch_taken: fd_flush=dx_flush=1, pc_en=fd_en=dx_en=1, md_go=0. md_insn and load_use_hazard are ignored because the squashed instructions are not real.
  2. md_insn: md_go=1, pc_en=fd_en=dx_en=0, xm_bubble=1, next state MD_BUSY, counter cleared to 0.
  3. load_use_hazard: pc_en=fd_en=0, dx_en=1, dx_bubble=1. There is one bubble per asserted cycle, and the flag self-clears once the load moves on.
  4. Otherwise: pc_en=fd_en=dx_en=1 and all other outputs are 0.
- MD_BUSY:
  - Default each cycle: pc_en=fd_en=dx_en=0, xm_bubble=1, counter increments. branch_taken and load_use_hazard are ignored because X holds the multdiv instruction.
  - md_ready=1: pc_en=fd_en=dx_en=1 and xm_bubble=0, so X/M captures the result. Next state is RUN.
  - Counter reaches MD_TIMEOUT−1 without md_ready: md_timeout=1 and the release is identical to md_ready. X/M captures the instruction so the exception path can tag it. Next state is RUN.
  - If md_ready and the timeout coincide, md_ready wins and md_timeout stays 0.
- md_go is asserted only in the RUN→MD_BUSY cycle. It is never re-asserted while in MD_BUSY.
- The counter is unsigned CNT_W bits. It never wraps, because the timeout fires first.

## Timing
- All RUN outputs are combinational from the inputs and the current state. The state and counter are registered.
- md_ready is sampled from the cycle after md_go onward. An md_ready in the md_go cycle is ignored.
- Minimum multdiv stall:
  - 2 cycles: the md_go cycle plus the md_ready cycle.
  - The pipeline advances at the end of the md_ready cycle.
- Maximum multdiv stall: MD_TIMEOUT+1 cycles, counting the md_go cycle.
- Load-use stall: exactly 1 cycle per hazard occurrence.
- Asserting reset_n low mid-MD_BUSY returns to RUN immediately and asynchronously. No md_timeout pulse is produced.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_count increments on every clock edge where reset_n=1 and pc_en=0.
  - It saturates at 0xFFFFFFFF and resets to 0.
- STALL_PERF_CNT_EN undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- Reset, then idle with no inputs asserted -> pc_en=fd_en=dx_en=1, all other outputs 0, stall_count=0.
- load_use_hazard high for 1 cycle -> that cycle pc_en=fd_en=0, dx_bubble=1; next cycle full advance; stall_count=1 (macro defined).
- md_insn, then md_ready 5 cycles after md_go -> md_go for exactly 1 cycle, 6 stall cycles, release on the md_ready cycle, stall_count=6.
- md_insn with md_ready never asserted, MD_TIMEOUT=48 -> md_timeout pulses on the 48th MD_BUSY cycle, FSM returns to RUN, full advance.
- branch_taken together with md_insn and load_use_hazard in RUN -> flushes only: md_go=0, FSM stays in RUN; branch_taken during MD_BUSY -> no flush.
- reset_n low on the 3rd MD_BUSY cycle -> outputs 0 immediately; after release the FSM is in RUN, and md_timeout never pulses.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : Hazard inputs and pipeline control outputs of the stall/flush
//               controller, bundled as one port. The pipeline (master) drives
//               the hazard/handshake flags; the controller (slave) drives the
//               latch enables, bubbles, flushes and multdiv start/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if;
  // hazard / handshake flags from the pipeline
  logic        load_use_hazard;
  logic        branch_taken;
  logic        md_insn;
  logic        md_ready;
  // pipeline control back to the datapath
  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        dx_bubble;
  logic        xm_bubble;
  logic        fd_flush;
  logic        dx_flush;
  logic        md_go;
  logic        md_timeout;
  logic [31:0] stall_count;

  modport master (
    output load_use_hazard, branch_taken, md_insn, md_ready,
    input  pc_en, fd_en, dx_en, dx_bubble, xm_bubble, fd_flush, dx_flush,
    input  md_go, md_timeout, stall_count
  );

  modport slave (
    input  load_use_hazard, branch_taken, md_insn, md_ready,
    output pc_en, fd_en, dx_en, dx_bubble, xm_bubble, fd_flush, dx_flush,
    output md_go, md_timeout, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Stall/flush controller for the 5-stage core. Resolves branch
//               redirects, multdiv waits and load-use hazards into PC/latch
//               enables, bubbles and flushes. The multdiv wait is guarded by
//               a watchdog so a hung unit releases after MD_TIMEOUT cycles.
//               Optional feature macro: STALL_PERF_CNT_EN builds a saturating
//               32-bit stall-cycle counter on stall_count (otherwise tied 0).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 48,  // 2 .. 2**CNT_W-1
  parameter int CNT_W      = 6
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  pipe_stall_ctrl_if.slave  bus
);

  // last counter value allowed in MD_BUSY before the watchdog releases
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_md_cnt;

  logic w_busy;
  logic w_cnt_last;
  logic w_md_release;
  logic w_timeout_fire;
  logic w_enter_md;

  logic w_pc_en;
  logic w_fd_en;
  logic w_dx_en;
  logic w_dx_bubble;
  logic w_xm_bubble;
  logic w_fd_flush;
  logic w_dx_flush;
  logic w_md_go;
  logic w_md_timeout;

  // Branch squashes the younger instructions, so a multdiv behind it is not
  // real and must not start the unit.
  assign w_enter_md     = (r_state == ST_RUN) && !bus.branch_taken && bus.md_insn;
  assign w_busy         = (r_state == ST_MD_BUSY);
  assign w_cnt_last     = (r_md_cnt == c_TIMEOUT_LAST);
  // md_ready has priority; the watchdog only fires when the unit stayed silent
  assign w_md_release   = w_busy && (bus.md_ready || w_cnt_last);
  assign w_timeout_fire = w_busy && w_cnt_last && !bus.md_ready;

  // Combinational control decode; everything is forced low while in reset.
  always_comb begin
    w_pc_en      = 1'b0;
    w_fd_en      = 1'b0;
    w_dx_en      = 1'b0;
    w_dx_bubble  = 1'b0;
    w_xm_bubble  = 1'b0;
    w_fd_flush   = 1'b0;
    w_dx_flush   = 1'b0;
    w_md_go      = 1'b0;
    w_md_timeout = 1'b0;
    if (reset_n) begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.branch_taken) begin
            w_pc_en    = 1'b1;
            w_fd_en    = 1'b1;
            w_dx_en    = 1'b1;
            w_fd_flush = 1'b1;
            w_dx_flush = 1'b1;
          end else if (bus.md_insn) begin
            // hold F/D and D/X; X/M gets a nop while the unit computes
            w_md_go     = 1'b1;
            w_xm_bubble = 1'b1;
          end else if (bus.load_use_hazard) begin
            // freeze fetch/decode, push a nop into execute for one cycle
            w_dx_en     = 1'b1;
            w_dx_bubble = 1'b1;
          end else begin
            w_pc_en = 1'b1;
            w_fd_en = 1'b1;
            w_dx_en = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          if (w_md_release) begin
            // X/M captures the result (or the hung instruction on timeout)
            w_pc_en      = 1'b1;
            w_fd_en      = 1'b1;
            w_dx_en      = 1'b1;
            w_md_timeout = w_timeout_fire;
          end else begin
            w_xm_bubble = 1'b1;
          end
        end
        default: begin
          w_pc_en = 1'b0;
        end
      endcase
    end
  end

  // Multdiv wait FSM and watchdog counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_enter_md) begin
            r_state  <= ST_MD_BUSY;
            r_md_cnt <= '0;
          end
        end
        ST_MD_BUSY: begin
          if (w_md_release) begin
            r_state <= ST_RUN;
          end else begin
            // release happens at c_TIMEOUT_LAST, so this never wraps
            r_md_cnt <= r_md_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_en      = w_pc_en;
  assign bus.fd_en      = w_fd_en;
  assign bus.dx_en      = w_dx_en;
  assign bus.dx_bubble  = w_dx_bubble;
  assign bus.xm_bubble  = w_xm_bubble;
  assign bus.fd_flush   = w_fd_flush;
  assign bus.dx_flush   = w_dx_flush;
  assign bus.md_go      = w_md_go;
  assign bus.md_timeout = w_md_timeout;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of clock edges on which the PC was held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (!w_pc_en && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl
//               (MD_TIMEOUT=48, CNT_W=6). Honors STALL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  // expected output vectors:
  // {pc_en, fd_en, dx_en, dx_bubble, xm_bubble, fd_flush, dx_flush, md_go, md_timeout}
  localparam logic [8:0] c_ZERO  = 9'b000_00_00_00;
  localparam logic [8:0] c_ADV   = 9'b111_00_00_00;
  localparam logic [8:0] c_LU    = 9'b001_10_00_00;
  localparam logic [8:0] c_GO    = 9'b000_01_00_10;
  localparam logic [8:0] c_BUSY  = 9'b000_01_00_00;
  localparam logic [8:0] c_TMO   = 9'b111_00_00_01;
  localparam logic [8:0] c_FLUSH = 9'b111_00_11_00;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_fail;
  int   exp_stall;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MD_TIMEOUT (48),
    .CNT_W      (6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "time limit");
  end

  function automatic logic [8:0] outs();
    return {bus.pc_en, bus.fd_en, bus.dx_en, bus.dx_bubble, bus.xm_bubble,
            bus.fd_flush, bus.dx_flush, bus.md_go, bus.md_timeout};
  endfunction

  task automatic chk_outs(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = outs();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag);
    logic [31:0] exp;
`ifdef STALL_PERF_CNT_EN
    exp = 32'(exp_stall);
`else
    exp = 32'd0;
`endif
    n_cmp++;
    assert (bus.stall_count === exp) else begin
      n_fail++;
      $error("FAIL %s stall_count: observed=%0d expected=%0d", tag, bus.stall_count, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, let posedge act.
  task automatic step(input string tag, input logic lu, input logic br,
                      input logic mi, input logic mr, input logic [8:0] exp);
    @(negedge clock);
    bus.load_use_hazard = lu;
    bus.branch_taken    = br;
    bus.md_insn         = mi;
    bus.md_ready        = mr;
    #1;
    chk_outs(tag, exp);
    chk_stall(tag);
    if (reset_n && !exp[8]) exp_stall++;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    exp_stall = 0;
    reset_n   = 1'b0;
    bus.load_use_hazard = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.md_insn         = 1'b0;
    bus.md_ready        = 1'b0;

    // reset holds every output low, even with inputs asserted
    step("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, c_ZERO);
    step("reset_busy_inputs", 1'b1, 1'b1, 1'b1, 1'b1, c_ZERO);
    @(negedge clock);
    reset_n = 1'b1;

    // idle after reset
    step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);
    step("idle1", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // single load-use bubble
    step("load_use", 1'b1, 1'b0, 1'b0, 1'b0, c_LU);
    step("after_lu", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // multdiv with md_ready 5 cycles after md_go; md_ready in go cycle ignored
    step("md_go", 1'b0, 1'b0, 1'b1, 1'b1, c_GO);
    step("md_busy1", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("md_busy2_br_lu", 1'b1, 1'b1, 1'b1, 1'b0, c_BUSY);
    step("md_busy3", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("md_busy4", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("md_ready", 1'b0, 1'b0, 1'b1, 1'b1, c_ADV);
    step("after_md", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // branch beats multdiv and load-use; FSM must remain in RUN
    step("branch_all", 1'b1, 1'b1, 1'b1, 1'b0, c_FLUSH);
    step("after_branch", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // watchdog: timeout pulse on the 48th MD_BUSY cycle
    step("tmo_go", 1'b0, 1'b0, 1'b1, 1'b0, c_GO);
    for (int i = 0; i < 47; i++) step("tmo_busy", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("tmo_fire", 1'b0, 1'b0, 1'b1, 1'b0, c_TMO);
    step("after_tmo", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // md_ready coinciding with the timeout cycle wins, no md_timeout
    step("coin_go", 1'b0, 1'b0, 1'b1, 1'b0, c_GO);
    for (int i = 0; i < 47; i++) step("coin_busy", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("coin_ready", 1'b0, 1'b0, 1'b1, 1'b1, c_ADV);
    step("after_coin", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    // asynchronous reset on the 3rd MD_BUSY cycle
    step("rst_go", 1'b0, 1'b0, 1'b1, 1'b0, c_GO);
    step("rst_busy1", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("rst_busy2", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    step("rst_busy3", 1'b0, 1'b0, 1'b1, 1'b0, c_BUSY);
    #1;
    reset_n = 1'b0;
    #1;
    exp_stall = 0;
    chk_outs("async_reset", c_ZERO);
    chk_stall("async_reset");
    @(negedge clock);
    bus.md_insn = 1'b0;
    reset_n     = 1'b1;
    step("after_reset_run", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);
    for (int i = 0; i < 52; i++) step("no_timeout", 1'b0, 1'b0, 1'b0, 1'b0, c_ADV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
